servo_pwm_bank: RTL and testbench

Multi-channel hobby-servo PWM generator driving the plotter's pen and axis servos from one shared frame counter. Each channel holds a target pulse width that is written through a valid/ready port, clamped to a safe range, and applied only at frame boundaries. A per-frame slew limit moves the applied width toward the target. This replaces single-channel free-running servo drivers with a glitch-free, rate-limited bank.

---
 rtl/servo_pwm_bank_if.sv | 42 ++++
 rtl/servo_pwm_bank.sv | 139 +++++++++++++
 tb/tb_servo_pwm_bank.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_bank_if
//  Purpose  : Write port of the servo PWM bank. A single valid/ready channel
//             carries a channel index and a requested pulse width. An error
//             pulse returns to the writer when the index is out of range.
//  Ports    : wr_valid  - write request                    (master -> slave)
//             wr_ready  - write accept                     (slave  -> master)
//             wr_ch     - target channel index             (master -> slave)
//             wr_pulse  - requested pulse width in clocks  (master -> slave)
//             wr_err    - one-cycle bad-index pulse        (slave  -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface servo_pwm_bank_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 20
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_pulse;
  logic             wr_err;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_pulse,
    input  wr_ready,
    input  wr_err
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_pulse,
    output wr_ready,
    output wr_err
  );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_bank
//  Purpose  : Multi-channel hobby-servo PWM generator sharing one frame
//             counter. Each channel keeps a clamped target width and an
//             applied width; the applied width slews toward the target by at
//             most STEP once per frame, in the last frame cycle, so output
//             pulses are never truncated or glitched.
//  Ports    : clk         - system clock, rising edge
//             reset       - synchronous active-high reset
//             wr          - write port (servo_pwm_bank_if.slave)
//             enable      - per-channel output enable, taken at frame end
//             pwm         - registered servo pulse outputs
//             frame_start - one-cycle pulse on the first pwm cycle of a frame
//             busy        - per-channel applied width != target width
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_bank #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 20,
  parameter int PERIOD    = 1000000,
  parameter int MIN_PULSE = 50000,
  parameter int MAX_PULSE = 100000,
  parameter int NEUTRAL   = 75000,
  parameter int STEP      = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  servo_pwm_bank_if.slave       wr,
  input  logic [NUM_CH-1:0]     enable,
  output logic [NUM_CH-1:0]     pwm,
  output logic                  frame_start,
  output logic [NUM_CH-1:0]     busy
);
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] c_min     = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] c_max     = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] c_neutral = CNT_W'(NEUTRAL);
  localparam logic [CNT_W-1:0] c_step    = CNT_W'(STEP);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_err_q, wr_err_d;

  logic              w_last;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_wr_clamped;

  // Writes are refused only in the last frame cycle, so a target update can
  // never race the frame update that reads the target.
  assign w_last      = (cnt_q == c_last);
  assign wr.wr_ready = !reset && !w_last;
  assign w_xfer      = wr.wr_valid && wr.wr_ready;

  always_comb begin
    w_wr_clamped = wr.wr_pulse;
    if (wr.wr_pulse < c_min) begin
      w_wr_clamped = c_min;
    end else if (wr.wr_pulse > c_max) begin
      w_wr_clamped = c_max;
    end
  end

  always_comb begin
    cnt_d         = w_last ? '0 : cnt_q + CNT_W'(1);
    en_d          = w_last ? enable : en_q;
    // pwm is one clock behind cnt, so the frame's first pwm cycle follows cnt == 0.
    frame_start_d = (cnt_q == '0);
    wr_err_d      = w_xfer && (int'(wr.wr_ch) >= NUM_CH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      en_q          <= '0;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      en_q          <= en_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
    end
  end

  assign frame_start = frame_start_q;
  assign wr.wr_err   = wr_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] applied_q, applied_d;
    logic             pwm_q, pwm_d;

    always_comb begin
      target_d = target_q;
      if (w_xfer && (int'(wr.wr_ch) == i)) begin
        target_d = w_wr_clamped;
      end

      // Slew toward the target; both values are within the clamp range, so
      // the unsigned gaps below never wrap.
      applied_d = applied_q;
      if (w_last) begin
        if (target_q > applied_q) begin
          if ((STEP == 0) || ((target_q - applied_q) <= c_step)) begin
            applied_d = target_q;
          end else begin
            applied_d = applied_q + c_step;
          end
        end else begin
          if ((STEP == 0) || ((applied_q - target_q) <= c_step)) begin
            applied_d = target_q;
          end else begin
            applied_d = applied_q - c_step;
          end
        end
      end

      pwm_d = en_q[i] && (cnt_q < applied_q);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        target_q  <= c_neutral;
        applied_q <= c_neutral;
        pwm_q     <= 1'b0;
      end else begin
        target_q  <= target_d;
        applied_q <= applied_d;
        pwm_q     <= pwm_d;
      end
    end

    assign pwm[i]  = pwm_q;
    assign busy[i] = (applied_q != target_q);
  end
endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pwm_bank
//  Purpose  : Self-checking bench for servo_pwm_bank. A frame-level reference
//             model predicts every output each cycle; a vector table and
//             hand-written sequences check widths, clamping, write stalls,
//             bad-index errors (second build with one channel) and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_bank;
  localparam int NUM_CH    = 2;
  localparam int CNT_W     = 8;
  localparam int PERIOD    = 100;
  localparam int MIN_PULSE = 10;
  localparam int MAX_PULSE = 40;
  localparam int NEUTRAL   = 25;
  localparam int STEP      = 5;
  localparam int CH_W      = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] enable = '0;
  logic [NUM_CH-1:0] pwm, busy;
  logic              frame_start;
  logic [0:0]        enable1 = '0;
  logic [0:0]        pwm1, busy1;
  logic              frame_start1;

  servo_pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) wr_if ();
  servo_pwm_bank_if #(.NUM_CH(1), .CNT_W(CNT_W)) wr1_if ();

  servo_pwm_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE),
    .MAX_PULSE(MAX_PULSE), .NEUTRAL(NEUTRAL), .STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr_if), .enable(enable),
    .pwm(pwm), .frame_start(frame_start), .busy(busy)
  );

  servo_pwm_bank #(
    .NUM_CH(1), .CNT_W(CNT_W), .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE),
    .MAX_PULSE(MAX_PULSE), .NEUTRAL(NEUTRAL), .STEP(STEP)
  ) dut1 (
    .clk(clk), .reset(reset), .wr(wr1_if), .enable(enable1),
    .pwm(pwm1), .frame_start(frame_start1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position plus per-channel target/applied/enable.
  int m_cnt;
  int m_tgt [NUM_CH];
  int m_app [NUM_CH];
  bit m_en  [NUM_CH];
  bit m_err;
  bit m1_err;

  typedef struct {
    int ch;
    int pulse;
    int exp_w0;
    int exp_w1;
  } wr_vec_t;
  wr_vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < MIN_PULSE) return MIN_PULSE;
    if (v > MAX_PULSE) return MAX_PULSE;
    return v;
  endfunction

  function automatic int slew(input int app, input int tgt);
    int d;
    d = tgt - app;
    if (STEP == 0 || (d <= STEP && d >= -STEP)) return tgt;
    return (d > 0) ? app + STEP : app - STEP;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_err  = 1'b0;
    m1_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tgt[i] = NEUTRAL;
      m_app[i] = NEUTRAL;
      m_en[i]  = 1'b0;
    end
  endtask

  // Check every output of the current cycle, then advance one clock.
  task automatic step();
    bit acc, acc1;
    int ch, pulse, ch1, exp_pwm, exp_busy;
    logic [NUM_CH-1:0] en_cap;
    #1;
    exp_pwm  = 0;
    exp_busy = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_en[i] && m_cnt >= 1 && m_cnt <= m_app[i]) exp_pwm |= (1 << i);
      if (m_app[i] != m_tgt[i]) exp_busy |= (1 << i);
    end
    check("pwm", int'(pwm), exp_pwm);
    check("frame_start", int'(frame_start), (m_cnt == 1) ? 1 : 0);
    check("busy", int'(busy), exp_busy);
    check("wr_ready", int'(wr_if.wr_ready), (!reset && m_cnt != PERIOD - 1) ? 1 : 0);
    check("wr_err", int'(wr_if.wr_err), int'(m_err));
    check("wr_err_1ch", int'(wr1_if.wr_err), int'(m1_err));
    check("busy_1ch", int'(busy1), 0);
    check("pwm_1ch", int'(pwm1), 0);

    acc    = wr_if.wr_valid && !reset && (m_cnt != PERIOD - 1);
    acc1   = wr1_if.wr_valid && !reset && (m_cnt != PERIOD - 1);
    ch     = int'(wr_if.wr_ch);
    pulse  = int'(wr_if.wr_pulse);
    ch1    = int'(wr1_if.wr_ch);
    en_cap = enable;

    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_err  = acc && (ch >= NUM_CH);
      m1_err = acc1 && (ch1 >= 1);
      if (acc && ch < NUM_CH) m_tgt[ch] = clamp(pulse);
      if (m_cnt == PERIOD - 1) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_app[i] = slew(m_app[i], m_tgt[i]);
          m_en[i]  = en_cap[i];
        end
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
    #1;
  endtask

  task automatic step_until(input int c);
    int guard;
    guard = 0;
    while (m_cnt != c && guard < 2 * PERIOD) begin
      step();
      guard++;
    end
  endtask

  // Measure both channels' high time over one whole frame, starting at the
  // frame's first pwm cycle; optionally issue one write at cycle 10 of it.
  task automatic frame_widths(output int w0, output int w1,
                              input bit do_wr, input int wch, input int wpulse);
    step_until(1);
    w0 = 0;
    w1 = 0;
    for (int k = 0; k < PERIOD; k++) begin
      w0 += int'(pwm[0]);
      w1 += int'(pwm[1]);
      if (do_wr && k == 10) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = CH_W'(wch);
        wr_if.wr_pulse = CNT_W'(wpulse);
      end
      step();
      wr_if.wr_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, w1;
    wr_if.wr_valid  = 1'b0;
    wr_if.wr_ch     = '0;
    wr_if.wr_pulse  = '0;
    wr1_if.wr_valid = 1'b0;
    wr1_if.wr_ch    = '0;
    wr1_if.wr_pulse = '0;

    vecs[0] = '{1,   3, 40, 10};
    vecs[1] = '{1, 200, 40, 40};
    vecs[2] = '{0,   9, 10, 40};
    vecs[3] = '{0,  27, 27, 40};
    vecs[4] = '{1,   0, 27, 10};
    vecs[5] = '{0, 255, 40, 10};
    vecs[6] = '{1,  33, 40, 33};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    step();
    check("reset_pwm", int'(pwm), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_wr_err", int'(wr_if.wr_err), 0);
    check("reset_wr_ready", int'(wr_if.wr_ready), 0);
    reset  = 1'b0;
    enable = 2'b11;
    #1;
    check("ready_after_reset", int'(wr_if.wr_ready), 1);

    // Frame 1 silent, frame 2 neutral; write ch0=40 during frame 2
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("f1_w0", w0, 0);
    check("f1_w1", w1, 0);
    frame_widths(w0, w1, 1'b1, 0, 40);
    check("f2_w0", w0, 25);
    check("f2_w1", w1, 25);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("f3_w0", w0, 30);
    check("f3_w1", w1, 25);
    check("f4_busy0", int'(busy[0]), 1);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("f4_w0", w0, 35);
    check("f5_busy0", int'(busy[0]), 0);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("f5_w0", w0, 40);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("f6_w0", w0, 40);
    check("f6_w1", w1, 25);

    // Clamp/slew vector table: widths after the slew has settled
    for (int v = 0; v < 7; v++) begin
      frame_widths(w0, w1, 1'b1, vecs[v].ch, vecs[v].pulse);
      repeat (5) frame_widths(w0, w1, 1'b0, 0, 0);
      frame_widths(w0, w1, 1'b0, 0, 0);
      check($sformatf("vec%0d_w0", v), w0, vecs[v].exp_w0);
      check($sformatf("vec%0d_w1", v), w1, vecs[v].exp_w1);
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
    end

    // Write held across the last frame cycle stalls into the next frame
    step_until(PERIOD - 1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_ch    = 1'b1;
    wr_if.wr_pulse = 8'd20;
    #1;
    check("stall_ready_last", int'(wr_if.wr_ready), 0);
    step();
    #1;
    check("stall_ready_cnt0", int'(wr_if.wr_ready), 1);
    step();
    wr_if.wr_valid = 1'b0;
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("stall_same_frame_w1", w1, 33);
    check("stall_same_frame_w0", w0, 40);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("stall_next_frame_w1", w1, 28);

    // Reset for one cycle in the middle of a 40-clock pulse
    step_until(12);
    check("pwm0_mid_pulse", int'(pwm[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_busy", int'(busy), 0);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("midrst_f1_w0", w0, 0);
    check("midrst_f1_w1", w1, 0);
    frame_widths(w0, w1, 1'b0, 0, 0);
    check("midrst_f2_w0", w0, 25);
    check("midrst_f2_w1", w1, 25);

    // One-channel build: out-of-range index
    step_until(30);
    wr1_if.wr_valid = 1'b1;
    wr1_if.wr_ch    = 1'b1;
    wr1_if.wr_pulse = 8'd30;
    step();
    wr1_if.wr_valid = 1'b0;
    check("err1_pulse", int'(wr1_if.wr_err), 1);
    step();
    check("err1_clear", int'(wr1_if.wr_err), 0);
    check("err1_busy", int'(busy1), 0);

    // Randomized writes and enable changes against the model
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(5) == 0) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = CH_W'($urandom_range(1));
        wr_if.wr_pulse = CNT_W'($urandom_range(255));
      end else begin
        wr_if.wr_valid = 1'b0;
      end
      if ($urandom_range(149) == 0) enable = NUM_CH'($urandom_range(3));
      step();
    end
    wr_if.wr_valid = 1'b0;
    repeat (3 * PERIOD) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
